// File: rtl/seg_scan_ctl_if.sv
// seg_scan_ctl_if: display data/mask inputs and scan outputs of seg_scan_ctl.
// master = display-register side (drives data), slave = scan controller.
interface seg_scan_ctl_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    scan_en;
  logic [4*NUM_DIGITS-1:0] disp_data_pool;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   digit_en_mask;
  logic [7:0]              seg0;
  logic [7:0]              seg1;
  logic [NUM_DIGITS-1:0]   seg_flag;
  logic                    frame_done;

  modport master (
    output scan_en, disp_data_pool, dp_mask, digit_en_mask,
    input  seg0, seg1, seg_flag, frame_done
  );

  modport slave (
    input  scan_en, disp_data_pool, dp_mask, digit_en_mask,
    output seg0, seg1, seg_flag, frame_done
  );
endinterface

// File: rtl/seg_scan_ctl.sv
// seg_scan_ctl: multiplexed 7-segment scan controller.
// Upper half of the digits drive seg0, lower half drive seg1. The pool is
// snapshotted at each frame start so a frame never shows mixed data.
// Optional macro SEG_LEADING_ZERO_SUPPRESS_EN blanks leading zero digits.
//
// state | meaning
// IDLE  | not scanning, all outputs 0, waiting for scan_en
// SHOW  | digit idx lit for DWELL_CYCLES cycles
// BLANK | dead time after a digit, BLANK_CYCLES cycles
module seg_scan_ctl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DWELL_CYCLES = 1,
  parameter int BLANK_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  seg_scan_ctl_if.slave bus
);
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] HALF_IDX   = IDX_W'(NUM_DIGITS / 2);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        idx, idx_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [4*NUM_DIGITS-1:0] snap, snap_n;
  logic                    fd_n, adv;
  logic [7:0]              seg0_q, seg1_q, seg0_n, seg1_n, code;
  logic [NUM_DIGITS-1:0]   flag_q, flag_n;
  logic                    fd_q;
  logic [3:0]              nib;

  function automatic logic [7:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 8'hfc;  4'h1: decode = 8'h60;
      4'h2: decode = 8'hda;  4'h3: decode = 8'hf2;
      4'h4: decode = 8'h66;  4'h5: decode = 8'hb6;
      4'h6: decode = 8'hbe;  4'h7: decode = 8'he0;
      4'h8: decode = 8'hfe;  4'h9: decode = 8'hf6;
      4'ha: decode = 8'hee;  4'hb: decode = 8'h3e;
      4'hc: decode = 8'h9c;  4'hd: decode = 8'h7a;
      4'he: decode = 8'h9e;  default: decode = 8'h8e;
    endcase
  endfunction

`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
  // True when digit i and every digit above it are zero.
  function automatic logic upper_zero(input logic [4*NUM_DIGITS-1:0] s,
                                      input logic [IDX_W-1:0] i);
    logic z;
    z = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++)
      if (j >= int'(i) && s[j*4 +: 4] != 4'h0) z = 1'b0;
    return z;
  endfunction
`endif

  // State register, scan position, dwell/blank down-counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      snap   <= '0;
      seg0_q <= '0;
      seg1_q <= '0;
      flag_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      snap   <= snap_n;
      seg0_q <= seg0_n;
      seg1_q <= seg1_n;
      flag_q <= flag_n;
      fd_q   <= fd_n;
    end
  end

  // Next-state logic; scan_en only matters in IDLE and at the frame boundary.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    snap_n  = snap;
    fd_n    = 1'b0;
    adv     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.scan_en) begin
          state_n = SHOW;
          idx_n   = '0;
          cnt_n   = DWELL_LOAD;
          snap_n  = bus.disp_data_pool;
        end
      end
      SHOW: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (BLANK_CYCLES > 0) begin
          state_n = BLANK;
          cnt_n   = BLANK_LOAD;
        end else begin
          adv = 1'b1;
        end
      end
      BLANK: begin
        if (cnt != '0) cnt_n = cnt - 1'b1;
        else           adv   = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (adv) begin
      if (idx == LAST_IDX) begin
        fd_n  = 1'b1;
        idx_n = '0;
        if (bus.scan_en) begin
          state_n = SHOW;
          cnt_n   = DWELL_LOAD;
          snap_n  = bus.disp_data_pool;
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end else begin
        state_n = SHOW;
        idx_n   = idx + 1'b1;
        cnt_n   = DWELL_LOAD;
      end
    end
  end

  // Outputs are decoded from the next state so select and segments switch together.
  always_comb begin
    flag_n = '0;
    seg0_n = '0;
    seg1_n = '0;
    nib    = snap_n[idx_n*4 +: 4];
    code   = decode(nib);
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
    if (idx_n != '0 && upper_zero(snap_n, idx_n)) code = 8'h00;
`endif
    code = code | {7'b0, bus.dp_mask[idx_n]};
    if (state_n == SHOW && bus.digit_en_mask[idx_n]) begin
      flag_n[idx_n] = 1'b1;
      if (idx_n >= HALF_IDX) seg0_n = code;
      else                   seg1_n = code;
    end
  end

  assign bus.seg0       = seg0_q;
  assign bus.seg1       = seg1_q;
  assign bus.seg_flag   = flag_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctl.sv
// tb_seg_scan_ctl: two scan controllers (1/0 and 3/2 dwell/blank) share one
// stimulus stream. A frame-level reference model queues the expected outputs
// of every cycle; a monitor per instance pops and compares on the falling edge.
module tb_seg_scan_ctl;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         scan_en = 1'b0;
  logic [4*N-1:0] pool = '0;
  logic [N-1:0] dp = '0;
  logic [N-1:0] en = '0;
  int           tests = 0;
  int           fails = 0;

  logic [7:0] seg_tab [16] = '{8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66, 8'hb6, 8'hbe, 8'he0,
                               8'hfe, 8'hf6, 8'hee, 8'h3e, 8'h9c, 8'h7a, 8'h9e, 8'h8e};

  typedef struct packed {
    logic [N-1:0] flag;
    logic [7:0]   s0;
    logic [7:0]   s1;
    logic         fd;
  } obs_t;

  always #5 clk = ~clk;

  // Segment pattern of digit d from a frame snapshot and the live dp bit.
  function automatic logic [7:0] glyph(input logic [4*N-1:0] s, input int d, input logic dpb);
    logic [7:0] c;
    logic [3:0] nb;
    nb = s[d*4 +: 4];
    c  = seg_tab[nb];
`ifdef SEG_LEADING_ZERO_SUPPRESS_EN
    if (d > 0 && (s >> (4*d)) == '0) c = 8'h00;
`endif
    return c | {7'b0, dpb};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int DW = (g == 0) ? 1 : 3;
    localparam int BL = (g == 0) ? 0 : 2;

    seg_scan_ctl_if #(.NUM_DIGITS(N)) bus ();
    assign bus.scan_en        = scan_en;
    assign bus.disp_data_pool = pool;
    assign bus.dp_mask        = dp;
    assign bus.digit_en_mask  = en;

    seg_scan_ctl #(.NUM_DIGITS(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    obs_t           exp_q[$];
    int             frame_q[$];
    logic [4*N-1:0] snap = '0;
    logic           fd_next = 1'b0;

    // Reference model: a frame is a list of digit slots (-1 = blank cycle).
    always @(posedge clk) begin : model
      obs_t e;
      int   d;
      if (rst) begin
        frame_q.delete();
        fd_next = 1'b0;
      end else begin
        e       = '0;
        e.fd    = fd_next;
        fd_next = 1'b0;
        if (frame_q.size() == 0 && scan_en) begin
          snap = pool;
          for (int k = 0; k < N; k++) begin
            for (int c = 0; c < DW; c++) frame_q.push_back(k);
            for (int c = 0; c < BL; c++) frame_q.push_back(-1);
          end
        end
        if (frame_q.size() != 0) begin
          d = frame_q.pop_front();
          if (d >= 0 && en[d]) begin
            e.flag[d] = 1'b1;
            if (d >= N/2) e.s0 = glyph(snap, d, dp[d]);
            else          e.s1 = glyph(snap, d, dp[d]);
          end
          if (frame_q.size() == 0) fd_next = 1'b1;
        end
        exp_q.push_back(e);
      end
    end

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin : mon
      obs_t e;
      obs_t a;
      if (rst) begin
        exp_q.delete();
      end else begin
        a.flag = bus.seg_flag;
        a.s0   = bus.seg0;
        a.s1   = bus.seg1;
        a.fd   = bus.frame_done;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL dut%0d no_expectation t=%0t actual flag=%h seg0=%h seg1=%h fd=%b",
                   g, $time, a.flag, a.s0, a.s1, a.fd);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL dut%0d scan_out t=%0t actual flag=%h seg0=%h seg1=%h fd=%b required flag=%h seg0=%h seg1=%h fd=%b",
                     g, $time, a.flag, a.s0, a.s1, a.fd, e.flag, e.s0, e.s1, e.fd);
          end
        end
      end
    end

    // Asynchronous reset must clear the outputs without a clock edge.
    always @(posedge rst) begin : rchk
      #1;
      tests++;
      if (bus.seg_flag !== '0 || bus.seg0 !== 8'h00 || bus.seg1 !== 8'h00 || bus.frame_done !== 1'b0) begin
        fails++;
        $display("FAIL dut%0d async_reset t=%0t actual flag=%h seg0=%h seg1=%h fd=%b required all 0",
                 g, $time, bus.seg_flag, bus.seg0, bus.seg1, bus.frame_done);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
  endtask

  initial begin
    wait_cycles(2);
    scan_en = 1'b1;
    pool    = 32'h7654_3210;
    dp      = '0;
    en      = '1;
    rst     = 1'b0;
    wait_cycles(20);
    pool    = 32'hFFFF_FFFF;
    wait_cycles(100);
    en      = 8'hF0;
    dp      = 8'h10;
    pool    = 32'h7654_3210;
    wait_cycles(90);
    scan_en = 1'b0;
    wait_cycles(60);
    scan_en = 1'b1;
    en      = '1;
    dp      = '0;
    wait_cycles(55);
    mid_reset();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0:       pool = 32'($urandom_range(0, 4095));
        default: pool = $urandom;
      endcase
      dp      = N'($urandom);
      en      = ($urandom_range(0, 2) == 0) ? N'($urandom) : '1;
      scan_en = ($urandom_range(0, 4) != 0);
      wait_cycles($urandom_range(1, 45));
      if (it == 30) mid_reset();
    end
    scan_en = 1'b1;
    en      = '1;
    wait_cycles(50);
    scan_en = 1'b0;
    wait_cycles(50);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
